// File: rtl/pic_mem_arb_if.sv
// Bus bundle for the picture RAM arbiter.
// Display, loader, map-config, RAM and status signals in one interface.
interface pic_mem_arb_if #(
    parameter int DATA_W     = 3,
    parameter int FIFO_DEPTH = 4
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    logic              disp_mask;
    logic [2:0]        disp_slot;
    logic [14:0]       disp_addr;
    logic              frame_start;
    logic [DATA_W-1:0] disp_data;
    logic              disp_valid;

    logic              ld_valid;
    logic              ld_ready;
    logic [2:0]        ld_bank;
    logic [14:0]       ld_addr;
    logic [DATA_W-1:0] ld_data;

    logic              cfg_we;
    logic [2:0]        cfg_slot;
    logic [2:0]        cfg_bank;

    logic [17:0]       mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic [LW-1:0]     fifo_level;

    modport slave (
        input  disp_mask, disp_slot, disp_addr, frame_start,
        output disp_data, disp_valid,
        input  ld_valid, ld_bank, ld_addr, ld_data,
        output ld_ready,
        input  cfg_we, cfg_slot, cfg_bank,
        output mem_addr, mem_we, mem_wdata,
        input  mem_rdata,
        output fifo_level
    );

    modport master (
        output disp_mask, disp_slot, disp_addr, frame_start,
        input  disp_data, disp_valid,
        output ld_valid, ld_bank, ld_addr, ld_data,
        input  ld_ready,
        output cfg_we, cfg_slot, cfg_bank,
        input  mem_addr, mem_we, mem_wdata,
        output mem_rdata,
        input  fifo_level
    );
endinterface

// File: rtl/pic_mem_arb.sv
// Shared picture RAM arbiter: display reads win, loader writes drain
// from a small FIFO in blanking, slot->bank map swaps at frame start.
module pic_mem_arb #(
    parameter int DATA_W     = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    pic_mem_arb_if.slave   bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int EW = 18 + DATA_W;

    logic [2:0]        shadow_q [8];
    logic [2:0]        shadow_d [8];
    logic [2:0]        active_q [8];

    logic [EW-1:0]     fifo_q [FIFO_DEPTH];
    logic [AW-1:0]     wptr_q;
    logic [AW-1:0]     rptr_q;
    logic [LW-1:0]     level_q;

    logic [17:0]       mem_addr_q;
    logic              mem_we_q;
    logic [DATA_W-1:0] mem_wdata_q;

    logic              rd1_q;
    logic              rd2_q;
    logic [DATA_W-1:0] disp_data_q;
    logic              disp_valid_q;

    logic              push;
    logic              pop;
    logic              ready;
    logic [EW-1:0]     head;

    assign ready = level_q < LW'(FIFO_DEPTH);
    assign push  = bus.ld_valid & ready;
    assign pop   = ~bus.disp_mask & (level_q != '0);
    assign head  = fifo_q[rptr_q];

    // Shadow map with this cycle's config write merged in
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            shadow_d[i] = shadow_q[i];
        end
        if (bus.cfg_we) begin
            shadow_d[bus.cfg_slot] = bus.cfg_bank;
        end
    end

    // Map tables: shadow follows config, active copies it at frame start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                shadow_q[i] <= 3'(i);
                active_q[i] <= 3'(i);
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                shadow_q[i] <= shadow_d[i];
                if (bus.frame_start) begin
                    active_q[i] <= shadow_d[i];
                end
            end
        end
    end

    // Loader FIFO storage, pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            if (push) begin
                fifo_q[wptr_q] <= {bus.ld_bank, bus.ld_addr, bus.ld_data};
                wptr_q         <= wptr_q + AW'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + AW'(1);
            end
            if (push && !pop) begin
                level_q <= level_q + LW'(1);
            end else if (pop && !push) begin
                level_q <= level_q - LW'(1);
            end
        end
    end

    // Per-cycle RAM decision: display read, else queued write, else idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
        end else if (bus.disp_mask) begin
            mem_addr_q <= {active_q[bus.disp_slot], bus.disp_addr};
            mem_we_q   <= 1'b0;
        end else if (pop) begin
            mem_addr_q  <= head[EW-1 -: 18];
            mem_wdata_q <= head[DATA_W-1:0];
            mem_we_q    <= 1'b1;
        end else begin
            mem_we_q <= 1'b0;
        end
    end

    // Read-return pipeline aligning the valid flag with RAM data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd1_q        <= 1'b0;
            rd2_q        <= 1'b0;
            disp_valid_q <= 1'b0;
            disp_data_q  <= '0;
        end else begin
            rd1_q        <= bus.disp_mask;
            rd2_q        <= rd1_q;
            disp_valid_q <= rd2_q;
            if (rd2_q) begin
                disp_data_q <= bus.mem_rdata;
            end
        end
    end

    assign bus.ld_ready   = ready;
    assign bus.fifo_level = level_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.disp_data  = disp_data_q;
    assign bus.disp_valid = disp_valid_q;
endmodule

// File: tb/tb_pic_mem_arb.sv
// Testbench for pic_mem_arb: directed plan steps plus random traffic
// checked against a queue-based reference model and a RAM model.
module tb_pic_mem_arb;
    localparam int DW    = 3;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [2:0]    b;
        logic [14:0]   a;
        logic [DW-1:0] d;
    } ent_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pic_mem_arb_if #(.DATA_W(DW), .FIFO_DEPTH(DEPTH)) bus ();

    pic_mem_arb #(.DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] ram [logic [17:0]];
    logic [DW-1:0] pic [logic [17:0]];

    function automatic logic [DW-1:0] seed_pix(logic [17:0] a);
        return a[2:0] ^ a[17:15] ^ a[8:6];
    endfunction

    function automatic logic [DW-1:0] ram_rd(logic [17:0] a);
        return ram.exists(a) ? ram[a] : seed_pix(a);
    endfunction

    function automatic logic [DW-1:0] pix(logic [17:0] a);
        return pic.exists(a) ? pic[a] : seed_pix(a);
    endfunction

    // RAM: synchronous write, read data one cycle after address
    always @(posedge clk) begin
        if (bus.mem_we) ram[bus.mem_addr] = bus.mem_wdata;
        bus.mem_rdata <= ram_rd(bus.mem_addr);
    end

    // reference model state
    ent_t          q [$];
    logic [2:0]    sh [8];
    logic [2:0]    ac [8];
    logic [17:0]   e_addr;
    logic          e_we;
    logic [DW-1:0] e_wd;
    logic          pv [$];
    logic [DW-1:0] pd [$];
    logic [DW-1:0] e_dd;
    logic          pw_v;
    logic [17:0]   pw_a;
    logic [DW-1:0] pw_d;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        pv.delete();
        pd.delete();
        for (int i = 0; i < 8; i++) begin
            sh[i] = 3'(i);
            ac[i] = 3'(i);
        end
        e_addr = '0;
        e_we   = 1'b0;
        e_wd   = '0;
        e_dd   = '0;
        pw_v   = 1'b0;
        repeat (2) begin
            pv.push_back(1'b0);
            pd.push_back('0);
        end
    endtask

    task automatic idle();
        bus.disp_mask   = 1'b0;
        bus.disp_slot   = '0;
        bus.disp_addr   = '0;
        bus.frame_start = 1'b0;
        bus.ld_valid    = 1'b0;
        bus.ld_bank     = '0;
        bus.ld_addr     = '0;
        bus.ld_data     = '0;
        bus.cfg_we      = 1'b0;
        bus.cfg_slot    = '0;
        bus.cfg_bank    = '0;
    endtask

    task automatic setrd(input logic [2:0] s, input logic [14:0] a);
        bus.disp_mask = 1'b1;
        bus.disp_slot = s;
        bus.disp_addr = a;
    endtask

    task automatic setld(input logic v);
        bus.ld_valid = v;
        bus.ld_bank  = 3'($urandom_range(0, 7));
        bus.ld_addr  = 15'($urandom_range(0, 7));
        bus.ld_data  = DW'($urandom);
    endtask

    task automatic chk_reset();
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_mem_we", bus.mem_we, 0);
        chk("rst_mem_wdata", bus.mem_wdata, 0);
        chk("rst_disp_data", bus.disp_data, 0);
        chk("rst_disp_valid", bus.disp_valid, 0);
        chk("rst_ld_ready", bus.ld_ready, 1);
        chk("rst_fifo_level", bus.fifo_level, 0);
    endtask

    // one clock of stimulus, with model prediction and output checks
    task automatic cycle();
        ent_t          e;
        int            n;
        logic          rd;
        logic [DW-1:0] rp;
        logic          v;
        logic [DW-1:0] d;
        if (pw_v) begin
            pic[pw_a] = pw_d;
            pw_v = 1'b0;
        end
        n = q.size();
        chk("ld_ready", bus.ld_ready, 32'(n < DEPTH));
        chk("fifo_level", bus.fifo_level, n);
        rd = 1'b0;
        rp = '0;
        if (bus.disp_mask) begin
            e_addr = {ac[bus.disp_slot], bus.disp_addr};
            e_we = 1'b0;
            rd = 1'b1;
            rp = pix(e_addr);
        end else if (n > 0) begin
            e = q.pop_front();
            e_addr = {e.b, e.a};
            e_wd = e.d;
            e_we = 1'b1;
            pw_v = 1'b1;
            pw_a = e_addr;
            pw_d = e.d;
        end else begin
            e_we = 1'b0;
        end
        if (bus.ld_valid && n < DEPTH) begin
            e = {bus.ld_bank, bus.ld_addr, bus.ld_data};
            q.push_back(e);
        end
        if (bus.cfg_we) sh[bus.cfg_slot] = bus.cfg_bank;
        if (bus.frame_start) ac = sh;
        pv.push_back(rd);
        pd.push_back(rp);
        @(posedge clk);
        #1;
        chk("mem_addr", bus.mem_addr, e_addr);
        chk("mem_we", bus.mem_we, e_we);
        if (e_we) chk("mem_wdata", bus.mem_wdata, e_wd);
        v = pv.pop_front();
        d = pd.pop_front();
        if (v) e_dd = d;
        chk("disp_valid", bus.disp_valid, v);
        chk("disp_data", bus.disp_data, e_dd);
    endtask

    task automatic do_reset();
        idle();
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset();
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int wes;
        int run;
        logic m;
        idle();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_reset();
        rst_n = 1'b1;

        // identity map read through the full latency
        ram[{3'd5, 15'h1234}] = 3'b101;
        pic[{3'd5, 15'h1234}] = 3'b101;
        setrd(3'd5, 15'h1234);
        cycle();
        chk("id_addr", bus.mem_addr, 18'h29234);
        idle();
        cycle();
        cycle();
        chk("id_valid", bus.disp_valid, 1);
        chk("id_data", bus.disp_data, 3'b101);

        // map change deferred to frame start
        setrd(3'd0, 15'h0);
        bus.cfg_we = 1'b1;
        bus.cfg_slot = 3'd0;
        bus.cfg_bank = 3'd7;
        cycle();
        bus.cfg_we = 1'b0;
        cycle();
        chk("remap_defer", bus.mem_addr, 18'h00000);
        idle();
        bus.frame_start = 1'b1;
        cycle();
        bus.frame_start = 1'b0;
        setrd(3'd0, 15'h0);
        cycle();
        chk("remap_new", bus.mem_addr, 18'h38000);
        bus.cfg_we = 1'b1;
        bus.cfg_bank = 3'd2;
        bus.frame_start = 1'b1;
        cycle();
        chk("fs_same_old", bus.mem_addr, 18'h38000);
        bus.cfg_we = 1'b0;
        bus.frame_start = 1'b0;
        cycle();
        chk("fs_same_new", bus.mem_addr, 18'h10000);

        // starvation under mask, then drain in blanking
        setrd(3'd1, 15'h3);
        for (int i = 0; i < 4; i++) begin
            setld(1'b1);
            cycle();
        end
        chk("starve_ready", bus.ld_ready, 0);
        chk("starve_level", bus.fifo_level, 4);
        setld(1'b1);
        cycle();
        idle();
        wes = 0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            if (bus.mem_we) wes++;
        end
        chk("drain_cnt", wes, 4);
        chk("drain_ready", bus.ld_ready, 1);
        cycle();

        // push/pop overlap keeps the level steady
        setrd(3'd2, 15'h1);
        for (int i = 0; i < 2; i++) begin
            setld(1'b1);
            cycle();
        end
        bus.disp_mask = 1'b0;
        for (int i = 0; i < 5; i++) begin
            setld(1'b1);
            cycle();
        end
        chk("ovl_level", bus.fifo_level, 2);
        idle();
        repeat (3) cycle();

        // mask boundary 1->0->1 with queued writes
        setrd(3'd3, 15'h2);
        for (int i = 0; i < 3; i++) begin
            setld(1'b1);
            cycle();
        end
        bus.ld_valid = 1'b0;
        wes = 0;
        cycle();
        bus.disp_mask = 1'b0;
        cycle();
        if (bus.mem_we) wes++;
        bus.disp_mask = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            if (bus.mem_we) wes++;
        end
        chk("boundary_wr", wes, 1);
        idle();
        repeat (4) cycle();

        // async reset with queued writes and reads in flight
        setrd(3'd4, 15'h5);
        for (int i = 0; i < 3; i++) begin
            setld(1'b1);
            cycle();
        end
        do_reset();
        repeat (6) cycle();

        // randomized traffic
        run = 0;
        m = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            if (run == 0) begin
                m = ~m;
                run = $urandom_range(1, 12);
            end
            run--;
            bus.disp_mask = m;
            bus.disp_slot = 3'($urandom_range(0, 5));
            bus.disp_addr = 15'($urandom_range(0, 7));
            bus.frame_start = ($urandom_range(0, 39) == 0);
            bus.cfg_we = ($urandom_range(0, 15) == 0);
            bus.cfg_slot = 3'($urandom_range(0, 7));
            bus.cfg_bank = 3'($urandom_range(0, 7));
            setld($urandom_range(0, 1) == 1);
            if (c == 700) do_reset();
            else cycle();
        end
        idle();
        repeat (8) cycle();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
